// File: rtl/spi_master_param.sv
// Parametrised SPI master: FIFO-buffered transmit, full-duplex receive,
// programmable SCLK divider, run-time CPOL/CPHA latched per frame.
module spi_master_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_av,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              spi_miso,
  output logic              spi_mosi_out,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Bit-order helpers shared by the TX shift and the RX assembly.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic                cpol_l_q, cpol_l_d;
  logic                cpha_l_q, cpha_l_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                push;
  logic                pop;
  logic                div_last;
  logic [DATA_W-1:0]   head;

  assign head = fifo_mem_q[rd_ptr_q];

  // FIFO bookkeeping; a push while full is dropped and flagged.
  always_comb begin
    push       = data_av & ~full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CNT_FULL);
    overflow_d = overflow_q | (data_av & full_q);
  end

  always_ff @(posedge m_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= data_in;
  end

  // Frame sequencer; outputs are derived from the next-state values so they
  // change on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cpol_l_d   = cpol_l_q;
    cpha_l_d   = cpha_l_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    pop        = 1'b0;
    div_last   = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = cpol;
        if (count_q != '0) begin
          pop      = 1'b1;
          state_d  = ST_SETUP;
          div_d    = '0;
          cs_n_d   = 1'b0;
          cpol_l_d = cpol;
          cpha_l_d = cpha;
          if (!cpha) begin
            mosi_d  = first_bit(head);
            tx_sh_d = shift_out(head);
          end else begin
            tx_sh_d = head;
          end
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_XFER;
          div_d   = '0;
          edge_d  = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_XFER: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          // Even edge index = leading edge; sample where parity matches cpha.
          if (edge_q[0] == cpha_l_q) begin
            rx_sh_d = shift_in(rx_sh_q, spi_miso);
          end else if (edge_q != EDGE_LAST) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
          if (edge_q == EDGE_LAST) begin
            state_d = ST_HOLD;
            sclk_d  = cpol_l_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          state_d = ST_GAP;
          div_d   = '0;
          cs_n_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_last) begin
          state_d = ST_IDLE;
          div_d   = '0;
          sclk_d  = cpol;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase

    rx_valid_d = (state_d == ST_HOLD) && (div_d == DIV_LAST);
    rx_data_d  = rx_valid_d ? rx_sh_d : rx_data_q;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cpol_l_q   <= 1'b0;
      cpha_l_q   <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cpol_l_q   <= cpol_l_d;
      cpha_l_q   <= cpha_l_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign spi_mosi_out = mosi_q;
  assign spi_sclk     = sclk_q;
  assign spi_cs_n     = cs_n_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign fifo_full    = full_q;
  assign overflow     = overflow_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: 8-bit MSB-first and 16-bit LSB-first
// instances in MISO/MOSI loopback, observed by a per-frame bus monitor.
module tb_spi_master_param;

  logic        m_clk = 1'b0;
  logic        n_reset;
  logic        cpol, cpha;
  logic        sel16;

  logic [7:0]  din8;
  logic        av8, mosi8, sclk8, cs8, rxv8, full8, ovf8, busy8;
  logic [7:0]  rx8;
  logic [15:0] din16;
  logic        av16, mosi16, sclk16, cs16, rxv16, full16, ovf16, busy16;
  logic [15:0] rx16;

  always #5 m_clk = ~m_clk;

  spi_master_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(2), .MSB_FIRST(1)) u_dut8 (
    .m_clk(m_clk), .n_reset(n_reset), .data_in(din8), .data_av(av8),
    .cpol(cpol), .cpha(cpha), .spi_miso(mosi8), .spi_mosi_out(mosi8),
    .spi_sclk(sclk8), .spi_cs_n(cs8), .rx_data(rx8), .rx_valid(rxv8),
    .fifo_full(full8), .overflow(ovf8), .busy(busy8));

  spi_master_param #(.DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(2), .MSB_FIRST(0)) u_dut16 (
    .m_clk(m_clk), .n_reset(n_reset), .data_in(din16), .data_av(av16),
    .cpol(cpol), .cpha(cpha), .spi_miso(mosi16), .spi_mosi_out(mosi16),
    .spi_sclk(sclk16), .spi_cs_n(cs16), .rx_data(rx16), .rx_valid(rxv16),
    .fifo_full(full16), .overflow(ovf16), .busy(busy16));

  int n_checks = 0;
  int n_pass   = 0;

  // Bus monitor: per-frame statistics, latched when chip-select rises.
  int          cyc = 0, last_fall = 0;
  int          f_low = 0, f_samp = 0, f_edges = 0, f_bad = 0, f_valid = 0, f_period = 0;
  logic [31:0] f_bits = '0, f_rx = '0;
  logic        f_first = 1'b0, f_last = 1'b0;
  int          d_low = 0, d_samp = 0, d_edges = 0, d_bad = 0, d_valid = 0, d_period = 0;
  logic [31:0] d_bits = '0, d_rx = '0;
  logic        d_first = 1'b0, d_last = 1'b0;
  int          frames_done = 0, valid_total = 0;
  logic        prev_s = 1'b0, prev_c = 1'b1, prev_m = 1'b0;

  always @(negedge m_clk) begin
    logic s, c, m, v, lvl;
    logic [31:0] rd;
    s   = sel16 ? sclk16 : sclk8;
    c   = sel16 ? cs16 : cs8;
    m   = sel16 ? mosi16 : mosi8;
    v   = sel16 ? rxv16 : rxv8;
    rd  = sel16 ? {16'h0, rx16} : {24'h0, rx8};
    lvl = ~(cpol ^ cpha);
    cyc = cyc + 1;
    if (prev_c && !c) begin
      f_period = cyc - last_fall;
      last_fall = cyc;
      f_low = 0; f_samp = 0; f_edges = 0; f_bad = 0; f_valid = 0; f_bits = '0;
    end
    if (!c) begin
      f_low = f_low + 1;
      if (s != prev_s) begin
        f_edges = f_edges + 1;
        if (s == lvl) begin
          f_samp = f_samp + 1;
          f_bits = {f_bits[30:0], m};
          if (f_samp == 1) f_first = m;
          f_last = m;
          if (m != prev_m) f_bad = f_bad + 1;
        end
      end
    end
    if (v) begin
      f_valid = f_valid + 1;
      f_rx = rd;
      valid_total = valid_total + 1;
    end
    if (!prev_c && c) begin
      d_low = f_low; d_samp = f_samp; d_edges = f_edges; d_bad = f_bad;
      d_valid = f_valid; d_period = f_period; d_bits = f_bits; d_rx = f_rx;
      d_first = f_first; d_last = f_last;
      frames_done = frames_done + 1;
    end
    prev_s = s; prev_c = c; prev_m = m;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge m_clk);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_done < target && t < 2000) begin
      tick();
      t++;
    end
    check("frame_wait", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic push8(input logic [7:0] d);
    @(posedge m_clk); #1;
    din8 = d; av8 = 1'b1;
    @(posedge m_clk); #1;
    av8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] d);
    @(posedge m_clk); #1;
    din16 = d; av16 = 1'b1;
    @(posedge m_clk); #1;
    av16 = 1'b0;
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] exp_bits;
    logic [7:0] exp_rx;
    logic       exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base;
    int v_base;
    logic saw_busy, saw_cs;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, exp_bits: 8'hA5, exp_rx: 8'hA5, exp_last: 1'b1};
    vecs[1] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h3C, exp_bits: 8'h3C, exp_rx: 8'h3C, exp_last: 1'b0};
    vecs[2] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h96, exp_bits: 8'h96, exp_rx: 8'h96, exp_last: 1'b0};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'h81, exp_bits: 8'h81, exp_rx: 8'h81, exp_last: 1'b1};

    n_reset = 1'b0; cpol = 1'b0; cpha = 1'b0; sel16 = 1'b0;
    din8 = '0; av8 = 1'b0; din16 = '0; av16 = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", 32'(cs8), 32'd1);
    check("rst_sclk", 32'(sclk8), 32'd0);
    check("rst_mosi", 32'(mosi8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_rx_data", 32'(rx8), 32'd0);
    check("rst_rx_valid", 32'(rxv8), 32'd0);
    check("rst_overflow", 32'(ovf8), 32'd0);
    @(negedge m_clk);
    n_reset = 1'b1;
    repeat (3) tick();
    check("idle_cs_n", 32'(cs8), 32'd1);
    check("idle_sclk", 32'(sclk8), 32'd0);
    check("idle_busy", 32'(busy8), 32'd0);
    check("idle_full", 32'(full8), 32'd0);

    // Single frames in each SPI mode.
    for (int i = 0; i < 4; i++) begin
      cpol = vecs[i].cpol;
      cpha = vecs[i].cpha;
      repeat (3) tick();
      check($sformatf("v%0d_idle_sclk", i), 32'(sclk8), 32'(vecs[i].cpol));
      v_base = valid_total;
      base = frames_done;
      push8(vecs[i].tx);
      wait_frames(base + 1);
      check($sformatf("v%0d_mosi_bits", i), d_bits, 32'(vecs[i].exp_bits));
      check($sformatf("v%0d_rx_data", i), d_rx, 32'(vecs[i].exp_rx));
      check($sformatf("v%0d_cs_low", i), 32'(d_low), 32'd36);
      check($sformatf("v%0d_samples", i), 32'(d_samp), 32'd8);
      check($sformatf("v%0d_edges", i), 32'(d_edges), 32'd16);
      check($sformatf("v%0d_mosi_unstable", i), 32'(d_bad), 32'd0);
      check($sformatf("v%0d_rx_valid_cnt", i), 32'(valid_total - v_base), 32'd1);
      repeat (4) tick();
      check($sformatf("v%0d_post_sclk", i), 32'(sclk8), 32'(vecs[i].cpol));
      check($sformatf("v%0d_post_mosi", i), 32'(mosi8), 32'(vecs[i].exp_last));
      check($sformatf("v%0d_post_busy", i), 32'(busy8), 32'd0);
    end

    // Burst of six pushes into a four-deep FIFO while the first frame starts.
    cpol = 1'b0; cpha = 1'b0;
    repeat (3) tick();
    base = frames_done;
    @(posedge m_clk); #1;
    for (int w = 2; w <= 7; w++) begin
      din8 = 8'(w); av8 = 1'b1;
      @(posedge m_clk); #1;
    end
    av8 = 1'b0;
    tick();
    check("burst_fifo_full", 32'(full8), 32'd1);
    check("burst_overflow", 32'(ovf8), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_frames(base + k + 1);
      check($sformatf("burst%0d_bits", k), d_bits, 32'(k + 2));
      check($sformatf("burst%0d_rx", k), d_rx, 32'(k + 2));
      check($sformatf("burst%0d_cs_low", k), 32'(d_low), 32'd36);
      if (k > 0) check($sformatf("burst%0d_period", k), 32'(d_period), 32'd39);
    end
    repeat (60) tick();
    check("burst_frame_count", 32'(frames_done - base), 32'd5);
    check("burst_drained_busy", 32'(busy8), 32'd0);
    check("burst_drained_full", 32'(full8), 32'd0);
    check("burst_overflow_sticky", 32'(ovf8), 32'd1);

    // Reset in the middle of a transfer of 8'hFF.
    v_base = valid_total;
    push8(8'hFF);
    begin
      int t = 0;
      while (!(cs8 == 1'b0 && f_samp >= 3) && t < 500) begin
        tick();
        t++;
      end
    end
    check("abort_reached_bit3", 32'(f_samp), 32'd3);
    #1 n_reset = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs8), 32'd1);
    check("abort_sclk", 32'(sclk8), 32'd0);
    check("abort_mosi", 32'(mosi8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_overflow", 32'(ovf8), 32'd0);
    check("abort_rx_data", 32'(rx8), 32'd0);
    repeat (2) @(negedge m_clk);
    n_reset = 1'b1;
    saw_busy = 1'b0; saw_cs = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (busy8) saw_busy = 1'b1;
      if (!cs8) saw_cs = 1'b1;
    end
    check("abort_fifo_empty_busy", 32'(saw_busy), 32'd0);
    check("abort_fifo_empty_cs", 32'(saw_cs), 32'd0);
    check("abort_no_rx_valid", 32'(valid_total - v_base), 32'd0);

    // 16-bit LSB-first instance.
    sel16 = 1'b1;
    repeat (3) tick();
    base = frames_done;
    push16(16'h8001);
    wait_frames(base + 1);
    check("w16a_first_bit", 32'(d_first), 32'd1);
    check("w16a_last_bit", 32'(d_last), 32'd1);
    check("w16a_bits", d_bits, 32'h0000_8001);
    check("w16a_rx", d_rx, 32'h0000_8001);
    check("w16a_cs_low", 32'(d_low), 32'd68);
    check("w16a_samples", 32'(d_samp), 32'd16);
    check("w16a_valid", 32'(d_valid), 32'd1);
    repeat (4) tick();
    push16(16'h0003);
    wait_frames(base + 2);
    check("w16b_first_bit", 32'(d_first), 32'd1);
    check("w16b_last_bit", 32'(d_last), 32'd0);
    check("w16b_bits", d_bits, 32'h0000_C000);
    check("w16b_rx", d_rx, 32'h0000_0003);
    repeat (4) tick();
    check("w16_busy", 32'(busy16), 32'd0);
    check("w16_full", 32'(full16), 32'd0);
    check("w16_overflow", 32'(ovf16), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
